// File: rtl/sync_true_dpram_pkg.sv
// Shared constants for the synchronous true dual-port RAM.
package sync_true_dpram_pkg;

  localparam int unsigned WD_DEFAULT = 8;
  localparam int unsigned AD_DEFAULT = 4;

  function automatic int unsigned depth_of(input int unsigned ad);
    return 32'd1 << ad;
  endfunction

endpackage

// File: rtl/sync_true_dpram.sv
// Two read/write ports on one clock, shared active-low select; read-first,
// registered reads, port A wins same-address write collisions.
module sync_true_dpram
  import sync_true_dpram_pkg::*;
#(
  parameter int unsigned WD = WD_DEFAULT,
  parameter int unsigned AD = AD_DEFAULT
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          cs_n,
  input  logic          aw_r_n,
  input  logic [AD-1:0] addr_a,
  input  logic [WD-1:0] din_a,
  output logic [WD-1:0] dout_a,
  input  logic          bw_r_n,
  input  logic [AD-1:0] addr_b,
  input  logic [WD-1:0] din_b,
  output logic [WD-1:0] dout_b
);

  localparam int unsigned DEPTH = depth_of(AD);

  logic [WD-1:0] mem [DEPTH];
  logic          access;
  logic          we_a;
  logic          we_b;

  // B's write is suppressed on an address clash so A's data is what lands.
  always_comb begin
    access = !rst && !cs_n;
    we_a   = access && aw_r_n;
    we_b   = access && bw_r_n && !(we_a && (addr_a == addr_b));
  end

  always_ff @(posedge clk) begin
    if (we_a) mem[addr_a] <= din_a;
    if (we_b) mem[addr_b] <= din_b;
  end

  always_ff @(posedge clk) begin
    if (rst)
      dout_a <= '0;
    else if (!cs_n && !aw_r_n)
      dout_a <= mem[addr_a];
  end

  always_ff @(posedge clk) begin
    if (rst)
      dout_b <= '0;
    else if (!cs_n && !bw_r_n)
      dout_b <= mem[addr_b];
  end

endmodule

// File: tb/tb_sync_true_dpram.sv
// Directed + randomized bench for sync_true_dpram against an array reference model.
module tb_sync_true_dpram;

  logic       clk = 1'b0;
  logic       rst;
  logic       cs_n;
  logic       aw_r_n;
  logic [3:0] addr_a;
  logic [7:0] din_a;
  logic [7:0] dout_a;
  logic       bw_r_n;
  logic [3:0] addr_b;
  logic [7:0] din_b;
  logic [7:0] dout_b;

  sync_true_dpram #(.WD(8), .AD(4)) dut (
    .clk    (clk),
    .rst    (rst),
    .cs_n   (cs_n),
    .aw_r_n (aw_r_n),
    .addr_a (addr_a),
    .din_a  (din_a),
    .dout_a (dout_a),
    .bw_r_n (bw_r_n),
    .addr_b (addr_b),
    .din_b  (din_b),
    .dout_b (dout_b)
  );

  always #5 clk = ~clk;

  logic [7:0] ref_mem [16];
  bit         known   [16];
  logic [7:0] exp_a, exp_b;
  bit         ka, kb;
  int         vectors = 0;
  int         miscompares = 0;

  task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s observed=%02h expected=%02h", tag, obs, exp);
    end
  endtask

  task automatic drive(input bit r, input bit cs, input bit aw, input int aa, input int da,
                       input bit bw, input int ab, input int db);
    rst = r; cs_n = cs;
    aw_r_n = aw; addr_a = 4'(aa); din_a = 8'(da);
    bw_r_n = bw; addr_b = 4'(ab); din_b = 8'(db);
  endtask

  // Advance one edge: model reads see pre-edge contents, then writes apply (A last, so A wins).
  task automatic cycle();
    if (rst) begin
      exp_a = '0; exp_b = '0; ka = 1; kb = 1;
    end else if (!cs_n) begin
      if (!aw_r_n) begin exp_a = ref_mem[addr_a]; ka = known[addr_a]; end
      if (!bw_r_n) begin exp_b = ref_mem[addr_b]; kb = known[addr_b]; end
      if (bw_r_n) begin ref_mem[addr_b] = din_b; known[addr_b] = 1; end
      if (aw_r_n) begin ref_mem[addr_a] = din_a; known[addr_a] = 1; end
    end
    @(posedge clk);
    #1;
    if (ka) check("dout_a", dout_a, exp_a);
    if (kb) check("dout_b", dout_b, exp_b);
  endtask

  initial begin
    ka = 0; kb = 0; exp_a = '0; exp_b = '0;
    for (int i = 0; i < 16; i++) begin known[i] = 0; ref_mem[i] = '0; end

    // Initial reset
    drive(1, 1, 0, 0, 0, 0, 0, 0);
    cycle(); cycle();

    // Seed addr 3 = 0x55, addr 4 = 0x44
    drive(0, 0, 1, 3, 8'h55, 1, 4, 8'h44);
    cycle();

    // Reset with both ports writing must not touch memory
    drive(1, 0, 1, 3, 8'hFF, 1, 3, 8'hEE);
    cycle(); cycle();
    check("rst_dout_a", dout_a, 8'h00);
    check("rst_dout_b", dout_b, 8'h00);
    drive(0, 0, 0, 3, 0, 0, 4, 0);
    cycle();
    check("post_rst_mem3", dout_a, 8'h55);
    check("post_rst_mem4", dout_b, 8'h44);

    // Same-address write collisions, A must win
    for (int a = 0; a <= 8; a++) begin
      drive(0, 0, 1, a, 8'hA0 + a, 1, a, 8'hD0 + a);
      cycle();
    end
    // Fill remaining addresses
    for (int a = 9; a < 16; a++) begin
      drive(0, 0, 1, a, 8'h10 + a, 0, 0, 0);
      cycle();
    end

    // Dual read, opposite directions
    for (int i = 0; i <= 8; i++) begin
      drive(0, 0, 0, 9 - i, 0, 0, i, 0);
      cycle();
      check("collision_b", dout_b, 8'hA0 + 8'(i));
    end

    // A writes while B reads same address: read-first
    drive(0, 0, 1, 5, 8'hA5, 0, 0, 0);
    cycle();
    drive(0, 0, 1, 5, 8'hB5, 0, 5, 0);
    cycle();
    check("read_first_old", dout_b, 8'hA5);
    drive(0, 0, 0, 0, 0, 0, 5, 0);
    cycle();
    check("read_first_new", dout_b, 8'hB5);

    // B writes high half while A reads low half
    for (int i = 0; i < 8; i++) begin
      drive(0, 0, 0, 7 - i, 0, 1, 15 - i, 8'hC0 + 15 - i);
      cycle();
    end

    // Deselect with writes requested: nothing changes, outputs hold
    drive(0, 0, 0, 1, 0, 0, 2, 0);
    cycle();
    for (int i = 0; i < 4; i++) begin
      drive(0, 1, 1, $urandom_range(15), $urandom_range(255), 1, $urandom_range(15), $urandom_range(255));
      cycle();
    end
    for (int a = 0; a < 16; a++) begin
      drive(0, 0, 0, a, 0, 0, 15 - a, 0);
      cycle();
    end

    // Randomized traffic
    for (int n = 0; n < 400; n++) begin
      drive($urandom_range(39) == 0, $urandom_range(4) == 0,
            $urandom_range(1) == 1, $urandom_range(15), $urandom_range(255),
            $urandom_range(1) == 1, ($urandom_range(3) == 0) ? int'(addr_a) : int'($urandom_range(15)),
            $urandom_range(255));
      cycle();
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
